// File: rtl/cpu_controller_if.sv
// Controller <-> testbench/datapath signal bundle.
interface cpu_controller_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic        illegal;

  modport master (
    output s, load, in,
    input  w, ALUop, shift, sximm8, sximm5, readnum, writenum,
           write, loada, loadb, loadc, loads, asel, bsel, vsel, illegal
  );

  modport slave (
    input  s, load, in,
    output w, ALUop, shift, sximm8, sximm5, readnum, writenum,
           write, loada, loadb, loadc, loads, asel, bsel, vsel, illegal
  );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle instruction controller: IR, decode FSM and Moore datapath controls.
module cpu_controller (
  input  logic              clk,
  input  logic              reset,
  cpu_controller_if.slave   bus
);

  localparam int unsigned IW = 16;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;

  logic        w_c, write_c, loada_c, loadb_c, loadc_c, loads_c;
  logic        asel_c, bsel_c, illegal_c;
  logic [1:0]  aluop_c, shift_c, vsel_c;
  logic [2:0]  readnum_c, writenum_c;
  state_e      out_state;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  // While reset is held the outputs look like WAIT regardless of the current state.
  assign out_state = reset ? S_WAIT : state_q;

  // State and instruction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR only accepts a new word while idle.
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_WAIT && bus.load) ir_d = bus.in;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:      if (bus.s) state_d = S_DECODE;
      S_DECODE: begin
        unique case ({opcode, op})
          5'b110_10:                     state_d = S_WRITE_IMM;
          5'b110_00, 5'b101_11:          state_d = S_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10: state_d = S_GET_A;
          default:                       state_d = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_EXEC;
      S_EXEC:      state_d = ({opcode, op} == 5'b101_01) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  // Moore output decode from state and IR.
  always_comb begin
    w_c        = 1'b0;
    write_c    = 1'b0;
    loada_c    = 1'b0;
    loadb_c    = 1'b0;
    loadc_c    = 1'b0;
    loads_c    = 1'b0;
    asel_c     = 1'b0;
    bsel_c     = 1'b0;
    illegal_c  = 1'b0;
    aluop_c    = 2'b00;
    shift_c    = 2'b00;
    vsel_c     = 2'b00;
    readnum_c  = 3'd0;
    writenum_c = 3'd0;
    unique case (out_state)
      S_WAIT: w_c = 1'b1;
      S_DECODE: begin
        unique case ({opcode, op})
          5'b110_10, 5'b110_00, 5'b101_11,
          5'b101_00, 5'b101_01, 5'b101_10: illegal_c = 1'b0;
          default:                         illegal_c = 1'b1;
        endcase
      end
      S_WRITE_IMM: begin
        writenum_c = rn;
        vsel_c     = 2'b01;
        write_c    = 1'b1;
      end
      S_GET_A: begin
        readnum_c = rn;
        loada_c   = 1'b1;
      end
      S_GET_B: begin
        readnum_c = rm;
        loadb_c   = 1'b1;
      end
      S_EXEC: begin
        shift_c = sh;
        loadc_c = 1'b1;
        if (opcode == 3'b101) begin
          aluop_c = op;
          asel_c  = (op == 2'b11);
          loads_c = (op == 2'b01);
        end else begin
          aluop_c = 2'b00;
          asel_c  = 1'b1;
        end
      end
      S_WRITE_REG: begin
        writenum_c = rd;
        vsel_c     = 2'b00;
        write_c    = 1'b1;
      end
      default: w_c = 1'b0;
    endcase
  end

  assign bus.w        = w_c;
  assign bus.write    = write_c;
  assign bus.loada    = loada_c;
  assign bus.loadb    = loadb_c;
  assign bus.loadc    = loadc_c;
  assign bus.loads    = loads_c;
  assign bus.asel     = asel_c;
  assign bus.bsel     = bsel_c;
  assign bus.illegal  = illegal_c;
  assign bus.ALUop    = aluop_c;
  assign bus.shift    = shift_c;
  assign bus.vsel     = vsel_c;
  assign bus.readnum  = readnum_c;
  assign bus.writenum = writenum_c;
  assign bus.sximm8   = {{(IW-8){ir_q[7]}}, ir_q[7:0]};
  assign bus.sximm5   = {{(IW-5){ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized scoreboard bench for cpu_controller.
module tb_cpu_controller;

  typedef struct packed {
    logic        w;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic        illegal;
  } out_t;

  logic clk;
  logic reset;
  cpu_controller_if bus ();

  cpu_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t        exp_q[$];
  string       name_q[$];
  logic [15:0] irlog_q[$];
  out_t        seq[$];
  string       seq_names[$];

  int checks = 0;
  int errors = 0;
  logic [15:0] ir_m;

  // Idle outputs: only w and the sign extensions of the held IR are non-zero.
  function automatic out_t idle_out(input logic [15:0] ir);
    out_t o;
    o = '0;
    o.sximm8 = 16'($signed(ir[7:0]));
    o.sximm5 = 16'($signed(ir[4:0]));
    o.w = 1'b1;
    return o;
  endfunction

  function automatic out_t busy_base(input logic [15:0] ir);
    out_t o;
    o = idle_out(ir);
    o.w = 1'b0;
    return o;
  endfunction

  // Expected per-cycle outputs after s is accepted, listed instruction by instruction.
  function automatic void build_seq(input logic [15:0] ir);
    out_t dec, ga, gb, ex, wr, wi;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    bit mov_imm, mov_reg, mvn, alu3;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5];
    sh = ir[4:3]; rm = ir[2:0];
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    mvn     = (opc == 3'b101) && (op == 2'b11);
    alu3    = (opc == 3'b101) && (op != 2'b11);
    seq.delete();
    seq_names.delete();

    dec = busy_base(ir);
    dec.illegal = !(mov_imm || mov_reg || mvn || alu3);
    seq.push_back(dec); seq_names.push_back("DECODE");
    if (dec.illegal) return;

    if (mov_imm) begin
      wi = busy_base(ir);
      wi.writenum = rn; wi.vsel = 2'b01; wi.write = 1'b1;
      seq.push_back(wi); seq_names.push_back("WRITE_IMM");
      return;
    end

    if (alu3) begin
      ga = busy_base(ir);
      ga.readnum = rn; ga.loada = 1'b1;
      seq.push_back(ga); seq_names.push_back("GET_A");
    end
    gb = busy_base(ir);
    gb.readnum = rm; gb.loadb = 1'b1;
    seq.push_back(gb); seq_names.push_back("GET_B");

    ex = busy_base(ir);
    ex.shift = sh; ex.loadc = 1'b1; ex.bsel = 1'b0;
    ex.aluop = mov_reg ? 2'b00 : op;
    ex.asel  = mov_reg || mvn;
    ex.loads = alu3 && (op == 2'b01);
    seq.push_back(ex); seq_names.push_back("EXEC");
    if (ex.loads) return;

    wr = busy_base(ir);
    wr.writenum = rd; wr.vsel = 2'b00; wr.write = 1'b1;
    seq.push_back(wr); seq_names.push_back("WRITE_REG");
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic step(input logic rst_v, input logic s_v, input logic ld_v,
                      input logic [15:0] in_v, input out_t e, input string nm);
    reset    = rst_v;
    bus.s    = s_v;
    bus.load = ld_v;
    bus.in   = in_v;
    exp_q.push_back(e);
    name_q.push_back(nm);
    irlog_q.push_back(ir_m);
    @(posedge clk);
    #1;
  endtask

  // One instruction: load/start in WAIT, then the sequence, optionally aborted by reset.
  task automatic run_instr(input logic [15:0] instr, input bit do_load, input int abort_at);
    step(1'b0, 1'b1, do_load, instr, idle_out(ir_m), "WAIT_START");
    if (do_load) ir_m = instr;
    build_seq(ir_m);
    for (int k = 0; k < seq.size(); k++) begin
      if (k == abort_at) begin
        step(1'b1, 1'($urandom), 1'b1, 16'($urandom), idle_out(ir_m), "RESET_ABORT");
        ir_m = 16'h0000;
        break;
      end
      step(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), seq[k], seq_names[k]);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [4:0] legal [6];
    logic [4:0] pick;
    legal[0] = 5'b110_10; legal[1] = 5'b110_00; legal[2] = 5'b101_11;
    legal[3] = 5'b101_00; legal[4] = 5'b101_01; legal[5] = 5'b101_10;
    if ($urandom_range(0, 9) < 8) begin
      pick = legal[$urandom_range(0, 5)];
      return {pick, 11'($urandom)};
    end
    return 16'($urandom);
  endfunction

  // Monitor: compare every DUT output against the queued expectation each mid-cycle.
  initial begin
    out_t act, e;
    string nm;
    logic [15:0] irl;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        irl = irlog_q.pop_front();
        act.w = bus.w; act.aluop = bus.ALUop; act.shift = bus.shift;
        act.sximm8 = bus.sximm8; act.sximm5 = bus.sximm5;
        act.readnum = bus.readnum; act.writenum = bus.writenum;
        act.write = bus.write; act.loada = bus.loada; act.loadb = bus.loadb;
        act.loadc = bus.loadc; act.loads = bus.loads; act.asel = bus.asel;
        act.bsel = bus.bsel; act.vsel = bus.vsel; act.illegal = bus.illegal;
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s ir=%h t=%0t: got %h expected %h", nm, irl, $time, act, e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int abort_at;
    logic [15:0] instr;
    reset = 1'b1; bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;
    ir_m = 16'h0000;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b1, 16'hFFFF, idle_out(16'h0000), "RESET_HOLD");
    step(1'b0, 1'b0, 1'b0, 16'h0000, idle_out(16'h0000), "IDLE_AFTER_RESET");

    // Directed instructions.
    run_instr(16'hD107, 1'b1, -1);
    run_instr(16'hD1F0, 1'b1, -1);
    run_instr(16'hA148, 1'b1, -1);
    run_instr(16'hA900, 1'b1, -1);
    run_instr(16'h0000, 1'b1, -1);
    run_instr(16'hA148, 1'b1, 2);
    run_instr(16'hA148, 1'b0, -1);
    run_instr(16'hC003, 1'b1, -1);
    run_instr(16'hB80B, 1'b1, -1);

    // Randomized traffic with idle cycles, reuse of the IR and occasional resets.
    for (int n = 0; n < 300; n++) begin
      instr = rand_instr();
      while ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          step(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), idle_out(ir_m), "RESET_IDLE");
          ir_m = 16'h0000;
        end else begin
          logic ld;
          logic [15:0] v;
          ld = 1'($urandom);
          v = rand_instr();
          step(1'b0, 1'b0, ld, v, idle_out(ir_m), "IDLE");
          if (ld) ir_m = v;
        end
      end
      build_seq($urandom_range(0, 4) == 0 ? ir_m : instr);
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(instr, $urandom_range(0, 4) != 0, abort_at);
    end

    step(1'b0, 1'b0, 1'b0, 16'h0000, idle_out(ir_m), "FINAL_IDLE");
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
